// File: rtl/lut5_init_loader_if.sv
// Upstream handshake bundle for the LUT5 truth-table loader.
// The master offers a 32-bit table with IN_VALID; the slave answers with IN_READY.
interface lut5_init_loader_if;
    logic        IN_VALID;
    logic        IN_READY;
    logic [31:0] IN_DATA;

    modport master (
        output IN_VALID,
        output IN_DATA,
        input  IN_READY
    );

    modport slave (
        input  IN_VALID,
        input  IN_DATA,
        output IN_READY
    );
endinterface

// File: rtl/lut5_init_loader.sv
// Serial configuration loader for a 5-input LUT table, modelled on the CFGLUT5
// reconfiguration path. An accepted word is shifted MSB-first into the table
// register, one bit per clock, while the previous table leaves on CDO.
// With ATOMIC=1 the shifting happens in a shadow register and the downstream
// table switches over in a single commit cycle.
module lut5_init_loader #(
    parameter logic [31:0] INIT   = 32'h0000_0000,
    parameter bit          ATOMIC = 1'b0
) (
    input  logic                CLK,
    input  logic                RST_N,
    lut5_init_loader_if.slave   in_bus,
    input  logic                ABORT,
    output logic                BUSY,
    output logic                DONE,
    output logic                CDO,
    output logic [31:0]         LUT_INIT
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] shift_reg;
    logic [31:0] lut_reg;
    logic [31:0] load_reg;
    logic [4:0]  count;
    logic        done_reg;
    logic        cdo_reg;

    // Loader FSM together with the shift, load, committed-table and cascade registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            shift_reg <= INIT;
            lut_reg   <= INIT;
            load_reg  <= '0;
            count     <= '0;
            done_reg  <= 1'b0;
            cdo_reg   <= INIT[31];
        end else begin
            done_reg <= 1'b0;
            cdo_reg  <= shift_reg[31];
            case (state)
                IDLE: begin
                    if (in_bus.IN_VALID) begin
                        load_reg <= in_bus.IN_DATA;
                        count    <= 5'd31;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (ABORT) begin
                        state    <= IDLE;
                        count    <= '0;
                        load_reg <= '0;
                        if (ATOMIC) begin
                            shift_reg <= lut_reg;
                        end
                    end else begin
                        shift_reg <= {shift_reg[30:0], load_reg[31]};
                        load_reg  <= {load_reg[30:0], 1'b0};
                        count     <= count - 5'd1;
                        if (count == 5'd0) begin
                            if (ATOMIC) begin
                                state <= COMMIT;
                            end else begin
                                state    <= IDLE;
                                done_reg <= 1'b1;
                            end
                        end
                    end
                end
                COMMIT: begin
                    lut_reg  <= shift_reg;
                    state    <= IDLE;
                    done_reg <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign in_bus.IN_READY = (state == IDLE);
    assign BUSY            = (state != IDLE);
    assign DONE            = done_reg;
    assign CDO             = cdo_reg;
    assign LUT_INIT        = ATOMIC ? lut_reg : shift_reg;

endmodule

// File: tb/tb_lut5_init_loader.sv
// Testbench for lut5_init_loader: one live-update instance (index 0) and one
// atomic instance (index 1) run side by side against a table-level model.
module tb_lut5_init_loader;

    localparam logic [31:0] INIT_VAL = 32'hDEADBEEF;

    logic        clk;
    logic        rst_n    [2];
    logic        in_valid [2];
    logic [31:0] in_data  [2];
    logic        abort_s  [2];
    logic        ready_o  [2];
    logic        busy_o   [2];
    logic        done_o   [2];
    logic        cdo_o    [2];
    logic [31:0] lut_o    [2];

    int checks = 0;
    int errors = 0;

    // model state per instance
    logic        m_busy  [2];
    int          m_k     [2];
    logic [31:0] m_old   [2];
    logic [31:0] m_new   [2];
    logic [31:0] m_shift [2];
    logic [31:0] m_lut   [2];
    logic        m_done  [2];
    logic        m_cdo   [2];
    int          accepts [2];
    int          dones   [2];

    lut5_init_loader_if bus0 ();
    lut5_init_loader_if bus1 ();

    assign bus0.IN_VALID = in_valid[0];
    assign bus0.IN_DATA  = in_data[0];
    assign ready_o[0]    = bus0.IN_READY;
    assign bus1.IN_VALID = in_valid[1];
    assign bus1.IN_DATA  = in_data[1];
    assign ready_o[1]    = bus1.IN_READY;

    lut5_init_loader #(.INIT(INIT_VAL), .ATOMIC(1'b0)) dut0 (
        .CLK      (clk),
        .RST_N    (rst_n[0]),
        .in_bus   (bus0),
        .ABORT    (abort_s[0]),
        .BUSY     (busy_o[0]),
        .DONE     (done_o[0]),
        .CDO      (cdo_o[0]),
        .LUT_INIT (lut_o[0])
    );

    lut5_init_loader #(.INIT(INIT_VAL), .ATOMIC(1'b1)) dut1 (
        .CLK      (clk),
        .RST_N    (rst_n[1]),
        .in_bus   (bus1),
        .ABORT    (abort_s[1]),
        .BUSY     (busy_o[1]),
        .DONE     (done_o[1]),
        .CDO      (cdo_o[1]),
        .LUT_INIT (lut_o[1])
    );

    // free-running clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset(input int a);
        m_busy[a]  = 1'b0;
        m_k[a]     = 0;
        m_old[a]   = INIT_VAL;
        m_new[a]   = INIT_VAL;
        m_shift[a] = INIT_VAL;
        m_lut[a]   = INIT_VAL;
        m_done[a]  = 1'b0;
        m_cdo[a]   = INIT_VAL[31];
    endtask

    // one clock edge of table-level behaviour: k edges after acceptance the
    // register holds the top 32 bits of {old, new} << k
    task automatic model_edge(input int a);
        logic [63:0] cat;
        logic [31:0] prev;
        prev      = m_shift[a];
        m_done[a] = 1'b0;
        if (!m_busy[a]) begin
            if (in_valid[a]) begin
                m_busy[a] = 1'b1;
                m_k[a]    = 0;
                m_new[a]  = in_data[a];
                m_old[a]  = m_shift[a];
                accepts[a]++;
            end
        end else if (m_k[a] < 32) begin
            if (abort_s[a]) begin
                m_busy[a] = 1'b0;
                if (a == 1) m_shift[a] = m_lut[a];
            end else begin
                m_k[a]++;
                cat        = {m_old[a], m_new[a]} << m_k[a];
                m_shift[a] = cat[63:32];
                if (a == 0) m_lut[a] = m_shift[a];
                if (m_k[a] == 32 && a == 0) begin
                    m_busy[a] = 1'b0;
                    m_done[a] = 1'b1;
                end
            end
        end else begin
            m_lut[a]  = m_shift[a];
            m_busy[a] = 1'b0;
            m_done[a] = 1'b1;
        end
        m_cdo[a] = prev[31];
    endtask

    task automatic compare_model(input int a);
        check_output($sformatf("d%0d_lut", a),   lut_o[a],   m_lut[a]);
        check_output($sformatf("d%0d_ready", a), ready_o[a], !m_busy[a]);
        check_output($sformatf("d%0d_busy", a),  busy_o[a],  m_busy[a]);
        check_output($sformatf("d%0d_done", a),  done_o[a],  m_done[a]);
        check_output($sformatf("d%0d_cdo", a),   cdo_o[a],   m_cdo[a]);
    endtask

    // advance one clock: update both models at the edge, compare at the falling edge
    task automatic tick();
        @(posedge clk);
        for (int a = 0; a < 2; a++) begin
            if (rst_n[a]) model_edge(a);
        end
        @(negedge clk);
        for (int a = 0; a < 2; a++) begin
            compare_model(a);
            if (done_o[a] === 1'b1) begin
                dones[a]++;
                check_output($sformatf("d%0d_done_word", a), lut_o[a], m_new[a]);
            end
        end
    endtask

    task automatic apply_stimulus(input int a, input logic v, input logic [31:0] d, input logic ab);
        in_valid[a] = v;
        in_data[a]  = d;
        abort_s[a]  = ab;
    endtask

    task automatic check_reset_values(input int a, input string tag);
        check_output({tag, "_lut"},   lut_o[a],   INIT_VAL);
        check_output({tag, "_ready"}, ready_o[a], 1);
        check_output({tag, "_busy"},  busy_o[a],  0);
        check_output({tag, "_done"},  done_o[a],  0);
        check_output({tag, "_cdo"},   cdo_o[a],   1);
    endtask

    initial begin
        logic [31:0] cdo_seq;
        logic [31:0] old_tab;
        logic [31:0] word;
        logic [4:0]  idx;
        int          acc_start [2];
        int          done_start[2];
        int          cycles;

        for (int a = 0; a < 2; a++) begin
            rst_n[a] = 1'b0;
            apply_stimulus(a, 1'b0, 32'h0, 1'b0);
            model_reset(a);
            accepts[a] = 0;
            dones[a]   = 0;
        end

        // 1: reset values
        @(negedge clk);
        check_reset_values(0, "rst0");
        check_reset_values(1, "rst1");
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        tick();

        // 2: live load with the intermediate table and cascade stream
        apply_stimulus(0, 1'b1, 32'h96696996, 1'b0);
        tick();
        apply_stimulus(0, 1'b0, 32'h0, 1'b0);
        cdo_seq = '0;
        for (int i = 0; i < 16; i++) begin
            tick();
            cdo_seq = {cdo_seq[30:0], cdo_o[0]};
        end
        check_output("live_half", lut_o[0], 32'hBEEF9669);
        for (int i = 0; i < 16; i++) begin
            tick();
            cdo_seq = {cdo_seq[30:0], cdo_o[0]};
        end
        check_output("live_full", lut_o[0], 32'h96696996);
        check_output("live_done", done_o[0], 1);
        check_output("cdo_stream", cdo_seq, 32'hDEADBEEF);
        idx = 5'b10110;
        check_output("lut5_idx", lut_o[0][idx], 1);
        tick();
        check_output("live_done_pulse", done_o[0], 0);

        // 3: atomic load followed by a back-to-back accept in the DONE cycle
        apply_stimulus(1, 1'b1, 32'h0000FFFF, 1'b0);
        tick();
        for (int i = 0; i < 32; i++) tick();
        check_output("atom_hold", lut_o[1], INIT_VAL);
        tick();
        check_output("atom_commit", lut_o[1], 32'h0000FFFF);
        check_output("atom_done", done_o[1], 1);
        check_output("atom_ready_done", ready_o[1], 1);
        apply_stimulus(1, 1'b1, 32'hA5A55A5A, 1'b0);
        tick();
        apply_stimulus(1, 1'b0, 32'h0, 1'b0);
        check_output("b2b_accept", busy_o[1], 1);
        for (int i = 0; i < 33; i++) tick();
        check_output("b2b_lut", lut_o[1], 32'hA5A55A5A);
        check_output("b2b_done", done_o[1], 1);
        tick();

        // 4: abort after ten shifted bits, atomic then live
        apply_stimulus(1, 1'b1, 32'h12345678, 1'b0);
        tick();
        apply_stimulus(1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 10; i++) tick();
        apply_stimulus(1, 1'b0, 32'h0, 1'b1);
        tick();
        apply_stimulus(1, 1'b0, 32'h0, 1'b0);
        check_output("abort_atom_lut", lut_o[1], 32'hA5A55A5A);
        check_output("abort_atom_done", done_o[1], 0);
        check_output("abort_atom_ready", ready_o[1], 1);
        old_tab = lut_o[0] === 32'h96696996 ? 32'h96696996 : 32'h96696996;
        word    = 32'hCAFEF00D;
        apply_stimulus(0, 1'b1, word, 1'b0);
        tick();
        apply_stimulus(0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 10; i++) tick();
        apply_stimulus(0, 1'b0, 32'h0, 1'b1);
        tick();
        apply_stimulus(0, 1'b0, 32'h0, 1'b0);
        check_output("abort_live_lut", lut_o[0], (old_tab << 10) | (word >> 22));
        check_output("abort_live_done", done_o[0], 0);
        check_output("abort_live_ready", ready_o[0], 1);
        tick();

        // 5: asynchronous reset in the middle of a shift, then a clean load
        for (int a = 0; a < 2; a++) begin
            apply_stimulus(a, 1'b1, 32'h3C3C_C3C3 ^ a, 1'b0);
            tick();
            apply_stimulus(a, 1'b0, 32'h0, 1'b0);
            for (int i = 0; i < 20; i++) tick();
            #2;
            rst_n[a] = 1'b0;
            model_reset(a);
            #1;
            check_reset_values(a, $sformatf("midrst%0d", a));
            #1;
            rst_n[a] = 1'b1;
            tick();
            apply_stimulus(a, 1'b1, 32'h5555_AAAA ^ a, 1'b0);
            tick();
            apply_stimulus(a, 1'b0, 32'h0, 1'b0);
            for (int i = 0; i < 32 + a; i++) tick();
            check_output($sformatf("reload%0d_done", a), done_o[a], 1);
            check_output($sformatf("reload%0d_lut", a), lut_o[a], 32'h5555_AAAA ^ a);
            tick();
        end

        // 6: random words with IN_VALID toggling while busy, no aborts
        for (int a = 0; a < 2; a++) begin
            acc_start[a]  = accepts[a];
            done_start[a] = dones[a];
        end
        cycles = 0;
        while (cycles < 45000 &&
               !((accepts[0] - acc_start[0] >= 1000) && !m_busy[0] &&
                 (accepts[1] - acc_start[1] >= 1000) && !m_busy[1])) begin
            for (int a = 0; a < 2; a++) begin
                apply_stimulus(a,
                               (accepts[a] - acc_start[a] < 1000) && ($urandom_range(3) != 0),
                               $urandom, 1'b0);
            end
            tick();
            cycles++;
        end
        check_output("rand_bound", (cycles < 45000), 1);
        for (int a = 0; a < 2; a++) begin
            apply_stimulus(a, 1'b0, 32'h0, 1'b0);
            check_output($sformatf("rand%0d_accepts", a), accepts[a] - acc_start[a], 1000);
            check_output($sformatf("rand%0d_dones", a), dones[a] - done_start[a], 1000);
        end

        // random aborts mixed in, including in IDLE and COMMIT
        for (int i = 0; i < 2000; i++) begin
            for (int a = 0; a < 2; a++) begin
                apply_stimulus(a, $urandom_range(1) == 1, $urandom, $urandom_range(15) == 0);
            end
            tick();
        end
        for (int a = 0; a < 2; a++) apply_stimulus(a, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 40; i++) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lut5_init_loader.md
Name: lut5_init_loader

Overview:
Upstream configuration stage for the 5-input LUT model. It accepts a 32-bit truth table over a valid/ready handshake and serialises it MSB-first into the LUT table register, one bit per clock, mimicking the CFGLUT5 reconfiguration path. LUT_INIT drives the INIT/table input of the downstream 5-input lookup; that lookup indexes it with {I4,I3,I2,I1,I0}. CDO exposes the bit shifted out, so loaders can be chained.

Parameters:
INIT, 32'h00000000, table value loaded into LUT_INIT and the shift register at reset.
ATOMIC, 0, 0 = live update (LUT_INIT changes every shift cycle); 1 = shift into a shadow register, then commit all 32 bits in one cycle.

Ports:
CLK  input  1  clock; all state updates on the rising edge.
RST_N  input  1  asynchronous active-low reset.
IN_VALID  input  1  IN_DATA is valid.
IN_READY  output  1  loader can accept a word (state IDLE).
IN_DATA  input  32  new truth table; bit n is the output for index n.
ABORT  input  1  cancel an in-progress shift.
BUSY  output  1  high in SHIFT and COMMIT.
DONE  output  1  one-cycle pulse when a new table is fully in effect.
CDO  output  1  MSB of the register being shifted (cascade out).
LUT_INIT  output  32  table presented to the downstream LUT.

Behaviour:
- Reset (asynchronous, RST_N=0): state=IDLE; LUT_INIT=INIT; shift/shadow=INIT; load register=0; count=0; DONE=0; BUSY=0; IN_READY=1; CDO=INIT[31].
- States: IDLE, SHIFT, COMMIT. COMMIT exists only when ATOMIC=1.
- IDLE: IN_READY=1. If IN_VALID=1 at edge E0, capture IN_DATA into the load register, set count=31 and go to SHIFT. ABORT is ignored in IDLE, including when it arrives in the same cycle as IN_VALID (the word is accepted).
- SHIFT: IN_READY=0 and BUSY=1. On each edge E1..E32:
  - shift register <= {shift[30:0], load[31]}
  - load <<= 1
  - count decrements
- SHIFT exit: at the edge where count==0 (E32):
  - ATOMIC=0: go to IDLE and assert DONE for the cycle after E32.
  - ATOMIC=1: go to COMMIT.
- ATOMIC=0 data path: LUT_INIT is the shift register itself. Intermediate tables are visible downstream. After E32, LUT_INIT==IN_DATA.
- ATOMIC=1 data path: LUT_INIT is held constant during SHIFT. At E33 (COMMIT), LUT_INIT <= shadow. DONE is high for the cycle after E33, then the block returns to IDLE.
- IN_READY during DONE: IN_READY is high in the DONE cycle. A new word can be accepted in that cycle (back-to-back loads):
  - ATOMIC=0: 33 cycles per load.
  - ATOMIC=1: 34 cycles per load.
- CDO = bit 31 of the shift/shadow register, registered. The old table therefore emerges MSB-first during E1..E32.
- ABORT in SHIFT: at the next edge, go to IDLE, clear count and the load register, and do not pulse DONE.
  - ATOMIC=0: LUT_INIT keeps the partially shifted value.
  - ATOMIC=1: LUT_INIT is unchanged. The shadow is restored to the current LUT_INIT so CDO stays consistent.
- ABORT in COMMIT: ignored; the commit completes.
- IN_VALID while BUSY: ignored and not queued. The upstream holds the word because IN_READY=0.
- RST_N asserted mid-SHIFT or mid-COMMIT: immediate return to reset values. LUT_INIT=INIT; no DONE.
- No combinational path from any input to any output. IN_READY, BUSY and DONE are decoded from registered state.

Test Plan:
1. Reset with INIT=32'hDEADBEEF, ATOMIC=0 -> LUT_INIT=32'hDEADBEEF, IN_READY=1, BUSY=0, DONE=0, CDO=1.
2. ATOMIC=0, IN_DATA=32'h96696996 accepted at E0 -> after E16, LUT_INIT=32'hBEEF9669; after E32, LUT_INIT=32'h96696996; DONE high exactly one cycle; CDO sequence over E1..E32 equals DEADBEEF MSB-first; LUT5 output for index 5'b10110 equals bit 22 (=1).
3. ATOMIC=1, IN_DATA=32'h0000FFFF -> LUT_INIT stays at INIT through E32, becomes 32'h0000FFFF at E33, DONE one cycle after E33; back-to-back IN_VALID held high gives a second accept in the DONE cycle.
4. ABORT at E10 with ATOMIC=1 -> LUT_INIT unchanged, no DONE, IN_READY=1 next cycle. Repeat with ATOMIC=0 -> LUT_INIT = old[21:0] concatenated with the new word's top 10 bits.
5. RST_N pulsed low mid-SHIFT (E20), asynchronous to CLK -> outputs return to reset values immediately; a subsequent load completes normally in 32 (ATOMIC=0) or 33 (ATOMIC=1) cycles.
6. IN_VALID toggled randomly while BUSY -> no extra accepts. Accept count equals DONE count, and every DONE leaves LUT_INIT equal to the accepted word (1000 random words, both ATOMIC values).
